// File: rtl/pipelined_datapath_if.sv
// Instruction/control inputs and status/writeback outputs of the pipelined datapath.
// The master side drives decoded instructions; the slave side is the datapath itself.
interface pipelined_datapath_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic [4:0]       Rd;
   logic [4:0]       Rn;
   logic [4:0]       Rm;
   logic             Reg2Loc;
   logic             RegWrite;
   logic             MemWrite;
   logic             MemToReg;
   logic             immSel;
   logic             ALUsrc;
   logic [2:0]       ALUop;
   logic [8:0]       DAddr9;
   logic [11:0]      Imm12;
   logic             byte_sel;
   logic             stall;
   logic             zero;
   logic             negative;
   logic             overflow;
   logic             carry_out;
   logic             wb_valid;
   logic [4:0]       wb_addr;
   logic [WIDTH-1:0] wb_data;

   modport master (
      output in_valid, Rd, Rn, Rm, Reg2Loc, RegWrite, MemWrite, MemToReg,
             immSel, ALUsrc, ALUop, DAddr9, Imm12, byte_sel,
      input  stall, zero, negative, overflow, carry_out, wb_valid, wb_addr, wb_data
   );

   modport slave (
      input  in_valid, Rd, Rn, Rm, Reg2Loc, RegWrite, MemWrite, MemToReg,
             immSel, ALUsrc, ALUop, DAddr9, Imm12, byte_sel,
      output stall, zero, negative, overflow, carry_out, wb_valid, wb_addr, wb_data
   );
endinterface

// File: rtl/pipelined_datapath.sv
// ID/EX/MEM/WB LEGv8 datapath with forwarding, load-use interlock, byte/word data memory
// and a registered writeback observation port.
module pipelined_datapath #(
   parameter int WIDTH     = 64,
   parameter int MEM_DEPTH = 1024
) (
   input  logic                clk,
   input  logic                reset,
   pipelined_datapath_if.slave bus
);
   localparam int LANE_W = $clog2(WIDTH / 8);
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam logic [4:0] XZR = 5'd31;

   logic [WIDTH-1:0] r_rf   [0:31];
   logic [WIDTH-1:0] r_dmem [0:MEM_DEPTH-1];

   logic             r_ex_valid, r_ex_regwrite, r_ex_memwrite, r_ex_memtoreg;
   logic             r_ex_alusrc, r_ex_byte;
   logic [2:0]       r_ex_aluop;
   logic [4:0]       r_ex_rd, r_ex_rn, r_ex_rb;
   logic [WIDTH-1:0] r_ex_a, r_ex_b, r_ex_imm;

   logic             r_mem_valid, r_mem_regwrite, r_mem_memwrite, r_mem_memtoreg, r_mem_byte;
   logic [4:0]       r_mem_rd;
   logic [WIDTH-1:0] r_mem_result, r_mem_sdata;

   logic             r_wb_valid, r_wb_regwrite;
   logic [4:0]       r_wb_addr;
   logic [WIDTH-1:0] r_wb_data;

   logic             r_zero, r_negative, r_overflow, r_carry;

   logic [4:0]       w_rb;
   logic             w_b_used, w_wb_we, w_load_use, w_accept;
   logic [WIDTH-1:0] w_rf_a, w_rf_b, w_imm;
   logic [WIDTH-1:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu_res;
   logic [WIDTH:0]   w_sum;
   logic             w_carry, w_ovf;
   logic [IDX_W-1:0]  w_idx;
   logic [LANE_W-1:0] w_lane;
   logic [WIDTH-1:0] w_rword, w_wword, w_load;
   logic [7:0]       w_rbyte;

   // ---------------- ID: register read, immediate, interlock ----------------
   assign w_rb     = bus.Reg2Loc ? bus.Rm : bus.Rd;
   assign w_b_used = ~bus.ALUsrc | bus.MemWrite;
   assign w_wb_we  = r_wb_valid & r_wb_regwrite & (r_wb_addr != XZR);

   // Write-through: a read of the register being written this cycle sees the new value.
   assign w_rf_a = (bus.Rn == XZR) ? '0 :
                   (w_wb_we && r_wb_addr == bus.Rn) ? r_wb_data : r_rf[bus.Rn];
   assign w_rf_b = (w_rb == XZR) ? '0 :
                   (w_wb_we && r_wb_addr == w_rb) ? r_wb_data : r_rf[w_rb];

   assign w_imm = bus.immSel ? {{(WIDTH-12){1'b0}}, bus.Imm12}
                             : {{(WIDTH-9){bus.DAddr9[8]}}, bus.DAddr9};

   assign w_load_use = bus.in_valid & r_ex_valid & r_ex_memtoreg & r_ex_regwrite &
                       (r_ex_rd != XZR) &
                       ((r_ex_rd == bus.Rn) | (w_b_used & (r_ex_rd == w_rb)));
   assign w_accept   = bus.in_valid & ~w_load_use;
   assign bus.stall  = w_load_use;

   // ---------------- EX: operand forwarding and ALU ----------------
   always_comb begin
      w_fwd_a = r_ex_a;
      if (r_ex_rn != XZR) begin
         if (r_mem_valid && r_mem_regwrite && r_mem_rd == r_ex_rn)
            w_fwd_a = r_mem_result;
         else if (r_wb_valid && r_wb_regwrite && r_wb_addr == r_ex_rn)
            w_fwd_a = r_wb_data;
      end
   end

   always_comb begin
      w_fwd_b = r_ex_b;
      if (r_ex_rb != XZR) begin
         if (r_mem_valid && r_mem_regwrite && r_mem_rd == r_ex_rb)
            w_fwd_b = r_mem_result;
         else if (r_wb_valid && r_wb_regwrite && r_wb_addr == r_ex_rb)
            w_fwd_b = r_wb_data;
      end
   end

   assign w_alu_b = r_ex_alusrc ? r_ex_imm : w_fwd_b;

   always_comb begin
      w_alu_res = '0;
      w_sum     = '0;
      w_carry   = 1'b0;
      w_ovf     = 1'b0;
      case (r_ex_aluop)
         3'b000: w_alu_res = w_alu_b;
         3'b010: begin
            w_sum     = {1'b0, w_fwd_a} + {1'b0, w_alu_b};
            w_alu_res = w_sum[WIDTH-1:0];
            w_carry   = w_sum[WIDTH];
            w_ovf     = (w_fwd_a[WIDTH-1] == w_alu_b[WIDTH-1]) &&
                        (w_alu_res[WIDTH-1] != w_fwd_a[WIDTH-1]);
         end
         3'b011: begin
            w_sum     = {1'b0, w_fwd_a} + {1'b0, ~w_alu_b} + {{WIDTH{1'b0}}, 1'b1};
            w_alu_res = w_sum[WIDTH-1:0];
            w_carry   = w_sum[WIDTH];
            w_ovf     = (w_fwd_a[WIDTH-1] != w_alu_b[WIDTH-1]) &&
                        (w_alu_res[WIDTH-1] != w_fwd_a[WIDTH-1]);
         end
         3'b100: w_alu_res = w_fwd_a & w_alu_b;
         3'b101: w_alu_res = w_fwd_a | w_alu_b;
         3'b110: w_alu_res = w_fwd_a ^ w_alu_b;
         default: w_alu_res = '0;
      endcase
   end

   // ---------------- MEM: address split, byte lanes ----------------
   assign w_idx   = r_mem_result[LANE_W +: IDX_W];
   assign w_lane  = r_mem_result[LANE_W-1:0];
   assign w_rword = r_dmem[w_idx];
   assign w_rbyte = w_rword[{w_lane, 3'b000} +: 8];
   assign w_load  = r_mem_byte ? {{(WIDTH-8){1'b0}}, w_rbyte} : w_rword;

   always_comb begin
      w_wword = r_mem_sdata;
      if (r_mem_byte) begin
         w_wword = w_rword;
         w_wword[{w_lane, 3'b000} +: 8] = r_mem_sdata[7:0];
      end
   end

   // Data memory is deliberately not reset; reset clears r_mem_valid so no write escapes.
   always_ff @(posedge clk) begin
      if (r_mem_valid && r_mem_memwrite)
         r_dmem[w_idx] <= w_wword;
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex_valid     <= 1'b0;
         r_ex_regwrite  <= 1'b0;
         r_ex_memwrite  <= 1'b0;
         r_ex_memtoreg  <= 1'b0;
         r_ex_alusrc    <= 1'b0;
         r_ex_byte      <= 1'b0;
         r_ex_aluop     <= '0;
         r_ex_rd        <= '0;
         r_ex_rn        <= '0;
         r_ex_rb        <= '0;
         r_ex_a         <= '0;
         r_ex_b         <= '0;
         r_ex_imm       <= '0;
         r_mem_valid    <= 1'b0;
         r_mem_regwrite <= 1'b0;
         r_mem_memwrite <= 1'b0;
         r_mem_memtoreg <= 1'b0;
         r_mem_byte     <= 1'b0;
         r_mem_rd       <= '0;
         r_mem_result   <= '0;
         r_mem_sdata    <= '0;
         r_wb_valid     <= 1'b0;
         r_wb_regwrite  <= 1'b0;
         r_wb_addr      <= '0;
         r_wb_data      <= '0;
         r_zero         <= 1'b0;
         r_negative     <= 1'b0;
         r_overflow     <= 1'b0;
         r_carry        <= 1'b0;
      end else begin
         r_ex_valid     <= w_accept;
         r_ex_regwrite  <= bus.RegWrite;
         r_ex_memwrite  <= bus.MemWrite;
         r_ex_memtoreg  <= bus.MemToReg;
         r_ex_alusrc    <= bus.ALUsrc;
         r_ex_byte      <= bus.byte_sel;
         r_ex_aluop     <= bus.ALUop;
         r_ex_rd        <= bus.Rd;
         r_ex_rn        <= bus.Rn;
         r_ex_rb        <= w_rb;
         r_ex_a         <= w_rf_a;
         r_ex_b         <= w_rf_b;
         r_ex_imm       <= w_imm;

         r_mem_valid    <= r_ex_valid;
         r_mem_regwrite <= r_ex_regwrite;
         r_mem_memwrite <= r_ex_memwrite;
         r_mem_memtoreg <= r_ex_memtoreg;
         r_mem_byte     <= r_ex_byte;
         r_mem_rd       <= r_ex_rd;
         r_mem_result   <= w_alu_res;
         r_mem_sdata    <= w_fwd_b;

         r_wb_valid     <= r_mem_valid;
         r_wb_regwrite  <= r_mem_regwrite;
         r_wb_addr      <= r_mem_rd;
         r_wb_data      <= r_mem_memtoreg ? w_load : r_mem_result;

         if (r_ex_valid) begin
            r_zero     <= (w_alu_res == '0);
            r_negative <= w_alu_res[WIDTH-1];
            r_overflow <= w_ovf;
            r_carry    <= w_carry;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            r_rf[i] <= '0;
      end else if (w_wb_we) begin
         r_rf[r_wb_addr] <= r_wb_data;
      end
   end

   assign bus.zero      = r_zero;
   assign bus.negative  = r_negative;
   assign bus.overflow  = r_overflow;
   assign bus.carry_out = r_carry;
   assign bus.wb_valid  = r_wb_valid;
   assign bus.wb_addr   = r_wb_addr;
   assign bus.wb_data   = r_wb_data;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench for pipelined_datapath: instruction table with hand-computed writeback
// results, plus sequences for flags, byte lanes and reset with the pipeline full.
module tb_pipelined_datapath;
   logic clk = 1'b0;
   logic reset = 1'b1;

   pipelined_datapath_if #(.WIDTH(64)) bus();

   pipelined_datapath #(.WIDTH(64), .MEM_DEPTH(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd, rn, rm;
      logic        reg2loc, regwrite, memwrite, memtoreg, immsel, alusrc;
      logic [2:0]  aluop;
      logic [8:0]  daddr;
      logic [11:0] imm;
      logic        bsel;
   } instr_t;

   typedef struct {
      logic        v;
      instr_t      ins;
      logic [4:0]  ea;
      logic [63:0] ed;
      int          es;
   } vec_t;

   typedef struct {
      logic [4:0]  a;
      logic [63:0] d;
   } exp_t;

   vec_t vt[$];
   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   function automatic instr_t r_type(input logic [2:0] op, input logic [4:0] rd, rn, rm);
      instr_t t = '0;
      t.rd = rd; t.rn = rn; t.rm = rm; t.reg2loc = 1'b1; t.regwrite = 1'b1; t.aluop = op;
      return t;
   endfunction

   function automatic instr_t i_type(input logic [2:0] op, input logic [4:0] rd, rn,
                                     input logic [11:0] imm);
      instr_t t = '0;
      t.rd = rd; t.rn = rn; t.reg2loc = 1'b1; t.regwrite = 1'b1; t.aluop = op;
      t.alusrc = 1'b1; t.immsel = 1'b1; t.imm = imm;
      return t;
   endfunction

   function automatic instr_t ld(input logic [4:0] rt, rn, input logic [8:0] off, input logic b);
      instr_t t = '0;
      t.rd = rt; t.rn = rn; t.regwrite = 1'b1; t.memtoreg = 1'b1; t.alusrc = 1'b1;
      t.aluop = 3'b010; t.daddr = off; t.bsel = b;
      return t;
   endfunction

   function automatic instr_t st(input logic [4:0] rt, rn, input logic [8:0] off, input logic b);
      instr_t t = '0;
      t.rd = rt; t.rn = rn; t.memwrite = 1'b1; t.alusrc = 1'b1;
      t.aluop = 3'b010; t.daddr = off; t.bsel = b;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act !== req)
         $display("FAIL %s actual=%h required=%h", name, act, req);
      else
         n_pass++;
   endtask

   task automatic drive(input logic v, input instr_t t);
      bus.in_valid = v;
      bus.Rd = t.rd; bus.Rn = t.rn; bus.Rm = t.rm;
      bus.Reg2Loc = t.reg2loc; bus.RegWrite = t.regwrite; bus.MemWrite = t.memwrite;
      bus.MemToReg = t.memtoreg; bus.immSel = t.immsel; bus.ALUsrc = t.alusrc;
      bus.ALUop = t.aluop; bus.DAddr9 = t.daddr; bus.Imm12 = t.imm; bus.byte_sel = t.bsel;
   endtask

   // Called just after a negedge; returns at the negedge following acceptance.
   task automatic issue(input logic v, input instr_t t, input logic [4:0] ea,
                        input logic [63:0] ed, input int es);
      int n;
      exp_t e;
      n = 0;
      drive(v, t);
      #1;
      while (bus.stall && n < 4) begin
         n++;
         @(negedge clk);
         #1;
      end
      if (v) chk("stall_cycles", 64'(n), 64'(es));
      @(negedge clk);
      if (v) begin
         e.a = ea; e.d = ed;
         exp_q.push_back(e);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic nop();
      issue(1'b0, '0, 5'd0, 64'd0, 0);
   endtask

   task automatic add_vec(input logic v, input instr_t t, input logic [4:0] ea,
                          input logic [63:0] ed, input int es);
      vec_t x;
      x.v = v; x.ins = t; x.ea = ea; x.ed = ed; x.es = es;
      vt.push_back(x);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'd0);
      chk({tag, "_wb_addr"},  64'(bus.wb_addr),  64'd0);
      chk({tag, "_wb_data"},  bus.wb_data,       64'd0);
      chk({tag, "_flags"}, 64'({bus.zero, bus.negative, bus.overflow, bus.carry_out}), 64'd0);
      chk({tag, "_stall"},    64'(bus.stall),    64'd0);
   endtask

   function automatic logic [63:0] flags();
      return 64'({bus.zero, bus.negative, bus.overflow, bus.carry_out});
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.wb_valid) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL wb_unexpected actual=X%0d:%h required=no writeback", bus.wb_addr, bus.wb_data);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("wb_X%0d", e.a), {bus.wb_addr, bus.wb_data[58:0]} , {e.a, e.d[58:0]});
            chk($sformatf("wb_X%0d_data", e.a), bus.wb_data, e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] v;
      logic [11:0] chunks [5];
      instr_t t;

      drive(1'b0, '0);
      // Main table: {valid, instruction, expected wb reg, expected wb data, expected stalls}
      add_vec(1, i_type(3'b010, 5'd1, 5'd31, 12'd5), 5'd1, 64'd5, 0);
      add_vec(1, i_type(3'b010, 5'd2, 5'd1, 12'd3), 5'd2, 64'd8, 0);
      add_vec(1, i_type(3'b010, 5'd9, 5'd31, 12'd9), 5'd9, 64'd9, 0);
      add_vec(0, '0, 5'd0, 64'd0, 0);
      add_vec(0, '0, 5'd0, 64'd0, 0);
      add_vec(1, r_type(3'b011, 5'd3, 5'd9, 5'd9), 5'd3, 64'd0, 0);
      add_vec(1, i_type(3'b010, 5'd10, 5'd31, 12'd20), 5'd10, 64'd20, 0);
      add_vec(0, '0, 5'd0, 64'd0, 0);
      add_vec(1, r_type(3'b010, 5'd11, 5'd10, 5'd1), 5'd11, 64'd25, 0);
      add_vec(1, st(5'd2, 5'd31, 9'd16, 1'b0), 5'd2, 64'd16, 0);
      add_vec(1, ld(5'd4, 5'd31, 9'd16, 1'b0), 5'd4, 64'd8, 0);
      add_vec(1, r_type(3'b010, 5'd5, 5'd4, 5'd4), 5'd5, 64'd16, 1);
      add_vec(1, ld(5'd12, 5'd31, 9'd16, 1'b0), 5'd12, 64'd8, 0);
      add_vec(1, r_type(3'b010, 5'd13, 5'd1, 5'd12), 5'd13, 64'd13, 1);
      add_vec(1, ld(5'd14, 5'd31, 9'd16, 1'b0), 5'd14, 64'd8, 0);
      t = i_type(3'b101, 5'd16, 5'd31, 12'h0F0);
      t.rm = 5'd14;
      add_vec(1, t, 5'd16, 64'h0F0, 0);
      add_vec(1, r_type(3'b100, 5'd17, 5'd2, 5'd5), 5'd17, 64'd0, 0);
      add_vec(1, r_type(3'b101, 5'd18, 5'd2, 5'd5), 5'd18, 64'd24, 0);
      add_vec(1, r_type(3'b110, 5'd19, 5'd18, 5'd2), 5'd19, 64'd16, 0);
      add_vec(1, i_type(3'b000, 5'd20, 5'd31, 12'hABC), 5'd20, 64'hABC, 0);
      add_vec(1, r_type(3'b111, 5'd21, 5'd1, 5'd2), 5'd21, 64'd0, 0);
      t = i_type(3'b010, 5'd22, 5'd31, 12'd0);
      t.immsel = 1'b0; t.daddr = 9'h1FF;
      add_vec(1, t, 5'd22, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      add_vec(1, i_type(3'b010, 5'd31, 5'd1, 12'd5), 5'd31, 64'd10, 0);
      add_vec(1, r_type(3'b010, 5'd23, 5'd31, 5'd1), 5'd23, 64'd5, 0);
      add_vec(1, i_type(3'b010, 5'd27, 5'd31, 12'd100), 5'd27, 64'd100, 0);
      add_vec(1, i_type(3'b010, 5'd28, 5'd31, 12'd1), 5'd28, 64'd1, 0);
      add_vec(1, ld(5'd30, 5'd31, 9'd16, 1'b0), 5'd30, 64'd8, 0);
      add_vec(1, r_type(3'b010, 5'd29, 5'd30, 5'd27), 5'd29, 64'd108, 1);
      add_vec(1, i_type(3'b010, 5'd26, 5'd31, 12'h800), 5'd26, 64'd2048, 0);
      add_vec(1, r_type(3'b010, 5'd26, 5'd26, 5'd26), 5'd26, 64'd4096, 0);
      add_vec(1, r_type(3'b010, 5'd26, 5'd26, 5'd26), 5'd26, 64'd8192, 0);
      add_vec(1, st(5'd1, 5'd26, 9'd24, 1'b0), 5'd1, 64'd8216, 0);
      add_vec(1, ld(5'd25, 5'd31, 9'd24, 1'b0), 5'd25, 64'd5, 0);
      add_vec(1, st(5'd1, 5'd31, 9'd40, 1'b0), 5'd1, 64'd40, 0);
      add_vec(1, r_type(3'b011, 5'd24, 5'd31, 5'd2), 5'd24, 64'hFFFF_FFFF_FFFF_FFF8, 0);
      add_vec(1, ld(5'd15, 5'd31, 9'd40, 1'b0), 5'd15, 64'd5, 0);
      add_vec(1, i_type(3'b010, 5'd3, 5'd31, 12'd33), 5'd3, 64'd33, 0);
      add_vec(1, st(5'd3, 5'd31, 9'd48, 1'b0), 5'd3, 64'd48, 0);
      add_vec(1, ld(5'd9, 5'd31, 9'd48, 1'b0), 5'd9, 64'd33, 0);
      add_vec(1, st(5'd1, 5'd31, 9'h1E8, 1'b0), 5'd1, 64'hFFFF_FFFF_FFFF_FFE8, 0);

      // Reset state
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;

      foreach (vt[i])
         issue(vt[i].v, vt[i].ins, vt[i].ea, vt[i].ed, vt[i].es);
      repeat (3) nop();

      // SUB of equal values: zero and carry set
      issue(1, r_type(3'b011, 5'd3, 5'd1, 5'd1), 5'd3, 64'd0, 0);
      @(negedge clk);
      chk("flags_sub_equal", flags(), 64'b1001);

      // 0x8000..0 minus 1: signed overflow, carry, positive result; bubbles hold flags
      v = 64'd1;
      issue(1, i_type(3'b010, 5'd20, 5'd31, 12'd1), 5'd20, v, 0);
      for (int k = 0; k < 63; k++) begin
         v = v << 1;
         issue(1, r_type(3'b010, 5'd20, 5'd20, 5'd20), 5'd20, v, 0);
      end
      issue(1, i_type(3'b011, 5'd21, 5'd20, 12'd1), 5'd21, 64'h7FFF_FFFF_FFFF_FFFF, 0);
      @(negedge clk);
      chk("flags_sub_ovf", flags(), 64'b0011);
      repeat (3) @(negedge clk);
      chk("flags_held_bubbles", flags(), 64'b0011);
      issue(1, i_type(3'b010, 5'd24, 5'd22, 12'd1), 5'd24, 64'd0, 0);
      @(negedge clk);
      chk("flags_add_wrap", flags(), 64'b1001);

      // Build X6 = 0x1122334455667788 by shift (self-add) and OR-immediate
      chunks[0] = 12'h122; chunks[1] = 12'h334; chunks[2] = 12'h455;
      chunks[3] = 12'h667; chunks[4] = 12'h788;
      v = 64'd1;
      issue(1, i_type(3'b010, 5'd6, 5'd31, 12'd1), 5'd6, v, 0);
      for (int c = 0; c < 5; c++) begin
         for (int k = 0; k < 12; k++) begin
            v = v << 1;
            issue(1, r_type(3'b010, 5'd6, 5'd6, 5'd6), 5'd6, v, 0);
         end
         v = v | {52'd0, chunks[c]};
         issue(1, i_type(3'b101, 5'd6, 5'd6, chunks[c]), 5'd6, v, 0);
      end
      issue(1, st(5'd2, 5'd31, 9'd0, 1'b0), 5'd2, 64'd0, 0);
      issue(1, st(5'd6, 5'd31, 9'd3, 1'b1), 5'd6, 64'd3, 0);
      issue(1, ld(5'd7, 5'd31, 9'd3, 1'b1), 5'd7, 64'h88, 0);
      issue(1, ld(5'd8, 5'd31, 9'd0, 1'b0), 5'd8, 64'h0000_0000_8800_0008, 0);
      issue(1, ld(5'd10, 5'd31, 9'd0, 1'b1), 5'd10, 64'h08, 0);
      repeat (4) nop();

      // Reset with the pipeline full: the in-flight store and write must be dropped
      issue(1, st(5'd22, 5'd31, 9'h1E8, 1'b0), 5'd22, 64'hFFFF_FFFF_FFFF_FFE8, 0);
      issue(1, i_type(3'b010, 5'd1, 5'd31, 12'd99), 5'd1, 64'd99, 0);
      chk("flags_before_reset", flags(), 64'b0100);
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_idle("midreset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_idle("after_reset");
      issue(1, ld(5'd7, 5'd31, 9'h1E8, 1'b0), 5'd7, 64'd5, 0);
      issue(1, i_type(3'b010, 5'd8, 5'd1, 12'd0), 5'd8, 64'd0, 0);
      repeat (5) nop();

      chk("wb_outstanding", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
